// File: rtl/commit_arbiter_v.sv
// commit_arbiter_v: round-robin arbiter sharing the Hazard Unit commit port among
// the per-lane vector reorder buffers, with a one-entry held-commit register.
module commit_arbiter_v #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned WIDTH_NO  = 8,
  parameter int unsigned WIDTH_CNT = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_LANES-1:0]              I_En_Lane,
  input  logic [NUM_LANES-1:0]              I_Req,
  input  logic [NUM_LANES-1:0]              I_Stall,
  input  logic [NUM_LANES*WIDTH_NO-1:0]     I_Commit_No,
  input  logic                              I_Commit_Ack,
  output logic [NUM_LANES-1:0]              O_Grant,
  output logic                              O_Commit_Req,
  output logic [$clog2(NUM_LANES)-1:0]      O_Commit_Lane,
  output logic [WIDTH_NO-1:0]               O_Commit_No,
  output logic [WIDTH_CNT-1:0]              O_Count,
  output logic                              O_Busy
);

  localparam int unsigned LW = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0] eligible;
  logic [WIDTH_NO-1:0]  lane_no [NUM_LANES];
  logic [LW-1:0]        ptr_q;
  logic [LW-1:0]        ptr_nxt;
  logic [LW-1:0]        scan_idx;
  logic [LW-1:0]        win_lane;
  logic [WIDTH_NO-1:0]  win_no;
  logic                 win_found;
  logic                 out_v_q;
  logic                 load;
  logic                 grant_v;

  // Unpack the flat per-lane commit-number bus.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
    assign lane_no[g] = I_Commit_No[g*WIDTH_NO +: WIDTH_NO];
  end

  assign eligible = I_Req & I_En_Lane & ~I_Stall;

  // A held commit that is being acked frees the slot in the same cycle.
  assign load    = ~out_v_q | I_Commit_Ack;
  assign grant_v = load & win_found;

  // First eligible lane scanning from ptr upward, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_lane  = '0;
    win_no    = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      scan_idx = LW'((32'(ptr_q) + k) % NUM_LANES);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_lane  = scan_idx;
        win_no    = lane_no[scan_idx];
      end
    end
  end

  // Pointer moves just past the winner.
  always_comb begin
    ptr_nxt = ptr_q;
    if (grant_v) begin
      ptr_nxt = (win_lane == LW'(NUM_LANES - 1)) ? '0 : win_lane + LW'(1);
    end
  end

  // Same-cycle one-hot pop toward the winning lane ROB; silenced during reset.
  always_comb begin
    O_Grant = '0;
    if (reset && grant_v) begin
      O_Grant[win_lane] = 1'b1;
    end
  end

  // Held-commit register, round-robin pointer and grant counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_v_q       <= 1'b0;
      O_Commit_Lane <= '0;
      O_Commit_No   <= '0;
      ptr_q         <= '0;
      O_Count       <= '0;
    end else if (grant_v) begin
      out_v_q       <= 1'b1;
      O_Commit_Lane <= win_lane;
      O_Commit_No   <= win_no;
      ptr_q         <= ptr_nxt;
      O_Count       <= O_Count + WIDTH_CNT'(1);
    end else if (I_Commit_Ack) begin
      out_v_q       <= 1'b0;
    end
  end

  assign O_Commit_Req = out_v_q;
  assign O_Busy       = out_v_q | (|eligible);

endmodule
